// File: rtl/router_pkg.sv
// Shared router definitions: direction numbering and the one-hot and index types
// used on the 5-port mesh router.
package router_pkg;

   localparam int NDIR = 5;

   localparam int DIR_PE = 0;
   localparam int DIR_S  = 1;
   localparam int DIR_N  = 2;
   localparam int DIR_E  = 3;
   localparam int DIR_W  = 4;

   typedef logic [NDIR-1:0] dir_onehot_t;
   typedef logic [2:0]      dir_idx_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: the first requester at or after ptr (wrapping 4->0)
// wins. Out-of-range pointers (5..7) search from index 0.
module rr_pick
   import router_pkg::*;
(
   input  dir_onehot_t req,
   input  dir_idx_t    ptr,
   output dir_onehot_t winner,
   output dir_idx_t    winner_idx
);

   dir_idx_t   start;
   logic [3:0] sum;
   dir_idx_t   idx;
   logic       found;

   always_comb begin
      winner     = '0;
      winner_idx = '0;
      found      = 1'b0;
      sum        = '0;
      idx        = '0;
      start      = (ptr > dir_idx_t'(NDIR - 1)) ? '0 : ptr;
      for (int k = 0; k < NDIR; k++) begin
         sum = {1'b0, start} + 4'(k);
         if (sum >= 4'(NDIR)) sum = sum - 4'(NDIR);
         idx = sum[2:0];
         if (!found && req[idx]) begin
            found       = 1'b1;
            winner[idx] = 1'b1;
            winner_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/oparb.sv
// Per-output-port round-robin arbiter with separate fairness pointers for the
// even and odd virtual channels; grant is combinational for same-cycle capture.
module oparb
   import router_pkg::*;
#(
   parameter int NREQ = 5,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            polarity,
   input  logic [NREQ-1:0] req,
   input  logic            out_empty,
   output logic [NREQ-1:0] grant,
   output logic            grant_valid,
   output logic [2:0]      ptr_even,
   output logic [2:0]      ptr_odd,
   output logic [CNTW-1:0] grant_cnt
);

   dir_idx_t    act_ptr;
   dir_onehot_t pick_oh;
   dir_idx_t    pick_idx;
   dir_idx_t    ptr_next;

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (&v) ? v : v + CNTW'(1);
   endfunction

   assign act_ptr = polarity ? ptr_odd : ptr_even;

   rr_pick u_pick (
      .req        (req),
      .ptr        (act_ptr),
      .winner     (pick_oh),
      .winner_idx (pick_idx)
   );

   // Only a slot that can actually capture the flit gets a grant.
   assign grant       = (reset || !out_empty) ? '0 : pick_oh;
   assign grant_valid = |grant;

   // Winner drops to lowest priority on its own VC.
   assign ptr_next = (pick_idx >= dir_idx_t'(NDIR - 1)) ? '0 : pick_idx + 3'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_even  <= '0;
         ptr_odd   <= '0;
         grant_cnt <= '0;
      end else if (grant_valid) begin
         if (polarity) ptr_odd  <= ptr_next;
         else          ptr_even <= ptr_next;
         grant_cnt <= sat_inc(grant_cnt);
      end
   end

   a_grant_onehot : assert property (@(posedge clk) $onehot0(grant));

endmodule

// File: tb/tb_oparb.sv
// Bench for oparb: directed scenarios followed by random traffic, all checked
// against a simple round-robin reference model.
module tb_oparb;

   logic       clk = 1'b0;
   logic       reset;
   logic       polarity;
   logic [4:0] req;
   logic       out_empty;

   logic [4:0]  grant,  grant_s;
   logic        grant_valid, grant_valid_s;
   logic [2:0]  ptr_even, ptr_odd, ptr_even_s, ptr_odd_s;
   logic [15:0] grant_cnt;
   logic [4:0]  grant_cnt_s;

   int errors = 0;
   int checks = 0;

   int m_ptr [2];
   int m_cnt;
   int m_cnt_s;
   int last_w;

   always #5 clk = ~clk;

   oparb #(.NREQ(5), .CNTW(16)) dut (
      .clk(clk), .reset(reset), .polarity(polarity), .req(req), .out_empty(out_empty),
      .grant(grant), .grant_valid(grant_valid), .ptr_even(ptr_even), .ptr_odd(ptr_odd),
      .grant_cnt(grant_cnt)
   );

   // Narrow-counter instance so saturation is reachable in a short run.
   oparb #(.NREQ(5), .CNTW(5)) dut_s (
      .clk(clk), .reset(reset), .polarity(polarity), .req(req), .out_empty(out_empty),
      .grant(grant_s), .grant_valid(grant_valid_s), .ptr_even(ptr_even_s), .ptr_odd(ptr_odd_s),
      .grant_cnt(grant_cnt_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cycle(input logic pol, input logic [4:0] rq, input logic emp, input logic rst);
      int w;
      logic [4:0] exp_g;
      @(negedge clk);
      polarity = pol; req = rq; out_empty = emp; reset = rst;
      #1;
      w = -1;
      for (int k = 0; k < 5; k++)
         if (w < 0 && rq[(m_ptr[pol] + k) % 5]) w = (m_ptr[pol] + k) % 5;
      exp_g = (rst || !emp || w < 0) ? 5'd0 : 5'(1 << w);
      last_w = (exp_g != 0) ? w : -1;
      check("grant", 32'(grant), 32'(exp_g));
      check("grant_valid", 32'(grant_valid), 32'(exp_g != 0));
      check("grant_s", 32'(grant_s), 32'(exp_g));
      @(posedge clk);
      #1;
      if (rst) begin
         m_ptr[0] = 0; m_ptr[1] = 0; m_cnt = 0; m_cnt_s = 0;
      end else if (exp_g != 0) begin
         m_ptr[pol] = (w + 1) % 5;
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt_s < 31) m_cnt_s++;
      end
      check("ptr_even", 32'(ptr_even), 32'(m_ptr[0]));
      check("ptr_odd", 32'(ptr_odd), 32'(m_ptr[1]));
      check("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
      check("grant_cnt_sat", 32'(grant_cnt_s), 32'(m_cnt_s));
   endtask

   initial begin
      m_ptr[0] = 0; m_ptr[1] = 0; m_cnt = 0; m_cnt_s = 0; last_w = -1;
      reset = 1'b1; polarity = 1'b0; req = 5'b11111; out_empty = 1'b1;

      // Reset while requests are pending: no grant, everything zero.
      cycle(1'b0, 5'b11111, 1'b1, 1'b1);
      cycle(1'b0, 5'b11111, 1'b1, 1'b1);

      // Full request on the even VC rotates PE, S, N, E, W.
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 5'b11111, 1'b1, 1'b0);
         check("rr_order", 32'(last_w), 32'(i));
      end
      check("ptr_even_wrapped", 32'(ptr_even), 32'd0);
      check("ptr_odd_frozen", 32'(ptr_odd), 32'd0);

      // Alternating polarity: each VC serves S then W independently.
      cycle(1'b0, 5'b11111, 1'b1, 1'b1);
      cycle(1'b0, 5'b10010, 1'b1, 1'b0);
      check("alt_even_first", 32'(last_w), 32'd1);
      cycle(1'b1, 5'b10010, 1'b1, 1'b0);
      check("alt_odd_first", 32'(last_w), 32'd1);
      cycle(1'b0, 5'b10010, 1'b1, 1'b0);
      check("alt_even_second", 32'(last_w), 32'd4);
      cycle(1'b1, 5'b10010, 1'b1, 1'b0);
      check("alt_odd_second", 32'(last_w), 32'd4);
      check("alt_cnt", 32'(grant_cnt), 32'd4);

      // Blocked slot: no grant, no pointer motion, then N once it drains.
      for (int i = 0; i < 3; i++) cycle(1'b0, 5'b00100, 1'b0, 1'b0);
      check("blocked_ptr", 32'(ptr_even), 32'd0);
      cycle(1'b0, 5'b00100, 1'b1, 1'b0);
      check("drain_grant_n", 32'(last_w), 32'd2);
      check("drain_ptr", 32'(ptr_even), 32'd3);

      // Wrap-around from ptr 3: PE beats S.
      cycle(1'b0, 5'b00011, 1'b1, 1'b0);
      check("wrap_pe", 32'(last_w), 32'd0);
      check("wrap_ptr", 32'(ptr_even), 32'd1);

      // Reset during a granting cycle.
      cycle(1'b1, 5'b11111, 1'b1, 1'b1);
      check("rst_cnt", 32'(grant_cnt), 32'd0);

      // Drive the narrow counter into saturation and hold it there.
      for (int i = 0; i < 40; i++) cycle(i[0], 5'b11111, 1'b1, 1'b0);
      check("sat_hold", 32'(grant_cnt_s), 32'd31);
      check("wide_cnt", 32'(grant_cnt), 32'd40);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/oparb.md
# oparb

Per-output-port round-robin arbiter for the 5-port router (PE, S, N, E, W). It selects one input buffer among those requesting this output port and drives the one-hot `grant` consumed by the output controller (`opctrl`) in the same cycle. It keeps separate fairness state for the even and odd virtual channels, selected by `polarity`. Only buffers that can actually be captured receive a grant: the output controller's current-polarity slot must be empty.

## Interface
- `NREQ`, 5: number of requesters; fixed at 5, bit order PE=0, S=1, N=2, E=3, W=4.
- `CNTW`, 16: width of the saturating grant counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `polarity`  in  1  0 = even VC cycle, 1 = odd VC cycle; toggles externally every cycle.
- `req`  in  NREQ  per-input request for this output port, for the VC selected by the current `polarity`.
- `out_empty`  in  1  `opctrl` `empty` for the current polarity slot.
- `grant`  out  NREQ  combinational one-hot grant; all-zero when no grant.
- `grant_valid`  out  1  OR-reduction of `grant`.
- `ptr_even`  out  3  registered round-robin pointer for the even VC, range 0..4.
- `ptr_odd`  out  3  registered round-robin pointer for the odd VC, range 0..4.
- `grant_cnt`  out  CNTW  registered total grants since reset; saturates at all-ones.

## Operation
- Active pointer is `ptr_even` when `polarity`=0 and `ptr_odd` when `polarity`=1.
- Priority search:
  - Start at index `ptr`, then ptr+1, … , wrapping 4→0.
  - The first index with `req` set wins.
- `grant` is the one-hot of the winner, or zero under any of these conditions:
  - `reset`=1;
  - `out_empty`=0;
  - `req`=0.
- Pointer update on a clock edge with `grant_valid`=1:
  - The active pointer loads (winner+1) mod 5, so the winner becomes lowest priority.
  - The inactive pointer is unchanged.
- With no grant, both pointers hold.
- `grant_cnt` increments by 1 on every granted edge, saturating at 2^CNTW−1.
- Pointer values 5..7 are illegal. If reached, the search treats them as 0, and the next update rewrites the pointer legally.
- Output is always one-hot or zero. A non-one-hot `grant` is a design error; assert it in simulation.

## Timing
- Reset values: `ptr_even`=0, `ptr_odd`=0, `grant_cnt`=0. While `reset` is high, `grant`=0 and `grant_valid`=0.
- Grant latency: combinational, zero cycles. `opctrl` samples `grant` at the same edge on which the pointer advances.
- Pointer update latency: 1 cycle. The next same-polarity cycle, which is two cycles later under alternating polarity, uses the new pointer.
- Simultaneous events:
  - `req` high together with `out_empty`=0: no grant and no pointer motion. The request persists and is served once the slot drains.
  - Single requester: granted regardless of pointer position.
  - All five requesting: winner is `ptr`.
- Reset mid-operation: takes effect at the next edge. It forces both pointers and the counter to 0; any grant in the reset cycle is suppressed.
- Polarity held constant: arbiter keeps serving that VC; the other pointer stays frozen.

## Structure
- Shared package `router_pkg`:
  - `NDIR`=5;
  - direction indices `DIR_PE`=0, `DIR_S`=1, `DIR_N`=2, `DIR_E`=3, `DIR_W`=4;
  - `dir_onehot_t` (5-bit);
  - `dir_idx_t` (3-bit).
- Sub-module `rr_pick`: purely combinational rotate-priority encoder. Inputs are `req` and `ptr`; outputs are the one-hot winner and the winner index. It is instantiated once and fed by the pointer muxed on `polarity`.
- `oparb` holds the two pointer registers, the counter, the gating by `out_empty`/`reset`, and the assertions.

## Test plan
- Reset, then `polarity`=0, `out_empty`=1, `req`=5'b11111 on 5 consecutive even cycles:
  - grants PE, S, N, E, W in order (00001, 00010, 00100, 01000, 10000);
  - `ptr_even` reads 1, 2, 3, 4, 0;
  - `ptr_odd` stays 0.
- Alternating polarity, `req`=5'b10010 every cycle:
  - even cycles grant S then W;
  - odd cycles independently grant S then W;
  - `grant_cnt`=4 after 4 cycles.
- `out_empty`=0 with `req`=5'b00100 for 3 cycles, then `out_empty`=1:
  - `grant`=0 and the pointer is unchanged during the blocked cycles;
  - N is granted on the first empty cycle.
- `ptr_even`=3, `req`=5'b00011:
  - wrap-around grants PE (00001);
  - `ptr_even` becomes 1.
- Assert `reset` during a granting cycle with `req`=5'b11111:
  - `grant`=0 in that cycle;
  - pointers and `grant_cnt` read 0 after the edge.
- Force `grant_cnt` to 16'hFFFE and grant 3 times: the counter reads FFFF and holds.
